// File: rtl/lpc_pkg.sv
// Shared LPC definitions: cycle types, bus codes, SYNC codes, size helpers, host states.
package lpc_pkg;

    // CYCTYPE field lives in nibble bits [3:2]; DIR is bit 1 (1 = write)
    localparam logic [1:0] CYC_IO  = 2'b00;
    localparam logic [1:0] CYC_MEM = 2'b01;
    localparam int unsigned DIR_BIT = 1;

    localparam logic [3:0] LAD_START = 4'h0;
    localparam logic [3:0] LAD_ABORT = 4'hF;

    localparam logic [3:0] SYNC_READY = 4'b0000;
    localparam logic [3:0] SYNC_SHORT = 4'b0101;
    localparam logic [3:0] SYNC_LONG  = 4'b0110;
    localparam logic [3:0] SYNC_ERR   = 4'b1010;

    typedef enum logic [3:0] {
        StIdle,
        StStart,
        StCycDir,
        StSize,
        StAddr,
        StWdata,
        StTar1,
        StTar2,
        StSync,
        StRdata,
        StTare1,
        StTare2,
        StAbort,
        StAbortEnd,
        StReject
    } lpc_state_e;

    // Byte count (1/2/4) to SIZE nibble
    function automatic logic [3:0] size_encode(input logic [2:0] bytes);
        case (bytes)
            3'd2:    size_encode = 4'b0001;
            3'd4:    size_encode = 4'b0011;
            default: size_encode = 4'b0000;
        endcase
    endfunction

    // SIZE nibble to byte count
    function automatic logic [2:0] size_decode(input logic [3:0] nib);
        case (nib)
            4'b0001: size_decode = 3'd2;
            4'b0011: size_decode = 3'd4;
            default: size_decode = 3'd1;
        endcase
    endfunction

    function automatic logic size_ok(input logic [2:0] bytes);
        size_ok = (bytes == 3'd1) || (bytes == 3'd2) || (bytes == 3'd4);
    endfunction

endpackage

// File: rtl/lpc_sync_timer.sv
// Saturating SYNC-phase timer; hit flags the increment that reaches the timeout.
module lpc_sync_timer #(
    parameter int unsigned SYNC_TIMEOUT = 32,
    parameter int unsigned TIMER_W      = 6
) (
    input  logic lpc_clock,
    input  logic lpc_reset,
    input  logic clear_i,
    input  logic en_i,
    output logic hit_o
);

    logic [TIMER_W-1:0] count_q, count_d;

    // Next count: clear wins, otherwise count enabled cycles up to the timeout
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != TIMER_W'(SYNC_TIMEOUT))) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign hit_o = en_i && (count_q == TIMER_W'(SYNC_TIMEOUT - 1));

endmodule

// File: rtl/lpc_host.sv
// LPC bus initiator: turns one local IO/memory request into a full LPC cycle.
module lpc_host
    import lpc_pkg::*;
#(
    parameter int unsigned SYNC_TIMEOUT = 32,
    parameter int unsigned TIMER_W      = 6
) (
    input  logic        lpc_clock,
    input  logic        lpc_reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_cyctype_dir,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [2:0]  req_data_size,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_error,
    input  logic [3:0]  lpc_ad_in,
    output logic [3:0]  lpc_ad_out,
    output logic        lpc_ad_oe,
    output logic        lpc_frame
);

    lpc_state_e  state_q;
    logic [3:0]  cyc_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] rdata_q;
    logic [2:0]  size_q;
    logic        err_q;
    logic [2:0]  cnt_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_data_q;
    logic        rsp_error_q;
    logic        frame_q;
    logic        oe_q;
    logic [3:0]  ad_q;

    logic        is_mem;
    logic        is_write;
    logic [2:0]  last_nib;
    logic [2:0]  cnt_dn;
    logic [2:0]  cnt_up;
    logic        sync_done;
    logic        sync_count;
    logic        timer_clr;
    logic        timer_hit;
    logic        req_bad;

    // Decode of the latched request and the SYNC sample
    always_comb begin
        is_mem     = (cyc_q[3:2] == CYC_MEM);
        is_write   = cyc_q[DIR_BIT];
        last_nib   = (size_q == 3'd4) ? 3'd7 : (size_q == 3'd2) ? 3'd3 : 3'd1;
        cnt_dn     = cnt_q - 3'd1;
        cnt_up     = cnt_q + 3'd1;
        sync_done  = (lpc_ad_in == SYNC_READY) || (lpc_ad_in == SYNC_ERR);
        // Short waits and unknown codes both consume timeout budget; long waits do not
        sync_count = (state_q == StSync) && !sync_done && (lpc_ad_in != SYNC_LONG);
        timer_clr  = (state_q == StTar2);
        req_bad    = !((req_cyctype_dir[3:2] == CYC_IO) || (req_cyctype_dir[3:2] == CYC_MEM)) ||
                     ((req_cyctype_dir[3:2] == CYC_MEM) && !size_ok(req_data_size));
    end

    lpc_sync_timer #(
        .SYNC_TIMEOUT(SYNC_TIMEOUT),
        .TIMER_W     (TIMER_W)
    ) u_sync_timer (
        .lpc_clock(lpc_clock),
        .lpc_reset(lpc_reset),
        .clear_i  (timer_clr),
        .en_i     (sync_count),
        .hit_o    (timer_hit)
    );

    // Bus-cycle FSM; every output is registered for the state being entered
    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            state_q     <= StIdle;
            cyc_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            rdata_q     <= '0;
            size_q      <= 3'd1;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
            frame_q     <= 1'b1;
            oe_q        <= 1'b0;
            ad_q        <= 4'hF;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    frame_q <= 1'b1;
                    oe_q    <= 1'b0;
                    ad_q    <= 4'hF;
                    if (req_ready_q && req_valid) begin
                        req_ready_q <= 1'b0;
                        cyc_q       <= req_cyctype_dir;
                        addr_q      <= req_addr;
                        data_q      <= req_data;
                        size_q      <= (req_cyctype_dir[3:2] == CYC_MEM) ? req_data_size : 3'd1;
                        rdata_q     <= '0;
                        err_q       <= 1'b0;
                        if (req_bad) begin
                            state_q <= StReject;
                        end else begin
                            state_q <= StStart;
                            frame_q <= 1'b0;
                            oe_q    <= 1'b1;
                            ad_q    <= LAD_START;
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                StStart: begin
                    state_q <= StCycDir;
                    frame_q <= 1'b1;
                    ad_q    <= cyc_q;
                end
                StCycDir: begin
                    if (is_mem) begin
                        state_q <= StSize;
                        ad_q    <= size_encode(size_q);
                    end else begin
                        state_q <= StAddr;
                        cnt_q   <= 3'd3;
                        ad_q    <= addr_q[15:12];
                    end
                end
                StSize: begin
                    state_q <= StAddr;
                    cnt_q   <= 3'd7;
                    ad_q    <= addr_q[31:28];
                end
                StAddr: begin
                    if (cnt_q != 3'd0) begin
                        cnt_q <= cnt_dn;
                        ad_q  <= addr_q[{cnt_dn, 2'b00} +: 4];
                    end else if (is_write) begin
                        state_q <= StWdata;
                        cnt_q   <= 3'd0;
                        ad_q    <= data_q[3:0];
                    end else begin
                        state_q <= StTar1;
                        ad_q    <= 4'hF;
                    end
                end
                StWdata: begin
                    if (cnt_q != last_nib) begin
                        cnt_q <= cnt_up;
                        ad_q  <= data_q[{cnt_up, 2'b00} +: 4];
                    end else begin
                        state_q <= StTar1;
                        ad_q    <= 4'hF;
                    end
                end
                StTar1: begin
                    state_q <= StTar2;
                    oe_q    <= 1'b0;
                end
                StTar2: begin
                    state_q <= StSync;
                end
                StSync: begin
                    if (sync_done) begin
                        err_q <= (lpc_ad_in == SYNC_ERR);
                        cnt_q <= 3'd0;
                        state_q <= is_write ? StTare1 : StRdata;
                    end else if (timer_hit) begin
                        state_q <= StAbort;
                        cnt_q   <= 3'd0;
                        frame_q <= 1'b0;
                        oe_q    <= 1'b1;
                        ad_q    <= LAD_ABORT;
                    end
                end
                StRdata: begin
                    rdata_q[{cnt_q, 2'b00} +: 4] <= lpc_ad_in;
                    if (cnt_q != last_nib) begin
                        cnt_q <= cnt_up;
                    end else begin
                        state_q <= StTare1;
                    end
                end
                StTare1: begin
                    state_q <= StTare2;
                end
                StTare2: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= is_write ? 32'h0 : rdata_q;
                    rsp_error_q <= err_q;
                end
                StAbort: begin
                    if (cnt_q != 3'd3) begin
                        cnt_q <= cnt_up;
                    end else begin
                        state_q <= StAbortEnd;
                        frame_q <= 1'b1;
                        oe_q    <= 1'b0;
                    end
                end
                StAbortEnd, StReject: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= 32'h0;
                    rsp_error_q <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_error  = rsp_error_q;
    assign lpc_ad_out = ad_q;
    assign lpc_ad_oe  = oe_q;
    assign lpc_frame  = frame_q;

endmodule
